axis_bcd_converter: RTL
=======================

// Module: axis_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double dabble) for the axis data path.
//  Consumes the 16-bit axis word selected by the axis data router (show_X/Y/Z) and produces
//  sign + decimal digits for the 7-segment display driver. One bit is processed per clock.
//  A start/busy/done handshake lets the display controller request a new conversion.
// PARAMETERS
//  DATA_W   16  width of binary input word
//  DIGITS   5   number of BCD output digits; must satisfy 10^DIGITS > 2^DATA_W (5 for 16)
//  SIGNED   1   1: input is two's complement, convert magnitude + report sign; 0: unsigned
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  reset      in   1          asynchronous, active-high reset
//  i_Data     in   DATA_W     binary word to convert (router DataOut)
//  i_Start    in   1          request conversion; sampled only in IDLE
//  o_Busy     out  1          high while a conversion is in progress
//  o_Done     out  1          one-cycle pulse when o_BCD/o_Sign update
//  o_Sign     out  1          1 = input was negative (always 0 when SIGNED=0)
//  o_BCD      out  4*DIGITS   digits, [3:0] = units, [4*DIGITS-1 -:4] = most significant
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, shift/BCD/count regs=0, o_Busy=0, o_Done=0,
//   o_Sign=0, o_BCD=0. Conversion in flight is discarded; no o_Done is produced.
//  States: IDLE, SHIFT. (2-state FSM + bit counter, width $clog2(DATA_W+1).)
//  IDLE: o_Busy=0. On edge with i_Start=1: latch magnitude of i_Data into shift reg,
//   latch sign, clear BCD working reg, count=0, go SHIFT. i_Data need not be held after.
//  Magnitude: SIGNED=1 and i_Data[DATA_W-1]=1 -> magnitude = (~i_Data)+1, treated as
//   unsigned DATA_W bits (0x8000 -> 32768, no overflow); else magnitude = i_Data.
//   Sign of zero is 0.
//  SHIFT: o_Busy=1. Each edge: every BCD digit >=5 gets +3, then {BCD,shift} shifted
//   left 1 with shift MSB entering BCD bit 0; count++.
//  On the edge performing shift number DATA_W (count==DATA_W-1): o_BCD <= final BCD
//   value, o_Sign <= latched sign, o_Done <= 1 for exactly that next cycle, state -> IDLE.
//  Latency: start accepted at edge N -> o_Done high and outputs valid after edge N+DATA_W.
//   Throughput: i_Start held high gives back-to-back conversions, one every DATA_W+1 cycles
//   (o_Done and next start acceptance coincide in the same IDLE cycle).
//  i_Start while SHIFT: ignored (not queued). o_Done never asserted outside that pulse.
//  o_BCD/o_Sign hold last completed result until next completion; they never show
//   partial values mid-conversion.
//  Each output digit is always 0..9; leading zeros are emitted (blanking is downstream).
// TESTING
//  1 reset, i_Data=0, pulse i_Start -> o_Done after 16 cycles, o_BCD=0x00000, o_Sign=0
//  2 i_Data=16'd12345, start -> o_BCD=0x12345, o_Sign=0; o_Busy high exactly 16 cycles
//  3 SIGNED=1: i_Data=16'hFFFF -> o_Sign=1, o_BCD=0x00001; 16'h8000 -> o_Sign=1, 0x32768;
//    16'h7FFF -> o_Sign=0, 0x32767
//  4 SIGNED=0: i_Data=16'hFFFF -> o_Sign=0, o_BCD=0x65535
//  5 start 00100, pulse i_Start again at cycle 5 with i_Data=999 -> single o_Done,
//    o_BCD=0x00100; i_Start held high -> o_Done every 17 cycles
//  6 start 12345 after prior result 0x00042, assert reset at cycle 8 -> outputs 0, no
//    o_Done; new start after release yields correct result; random compare vs model

Source files
------------

// File: rtl/axis_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Signed mode converts the two's-complement magnitude and reports the sign separately.

module axis_bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);
  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

module axis_bcd_converter #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     i_Data,
  input  logic                  i_Start,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Sign,
  output logic [4*DIGITS-1:0]   o_BCD
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]      shift_q, mag;
  logic                   sign_q, neg, last;
  logic [DIGITS-1:0][3:0] bcd_q, bcd_adj;
  logic [4*DIGITS:0]      bcd_shl;
  logic [CW-1:0]          cnt_q;

  // 0x8000 negates to itself, which read as unsigned is exactly the magnitude 32768
  assign neg  = (SIGNED != 0) && i_Data[DATA_W-1];
  assign mag  = neg ? (~i_Data + DATA_W'(1)) : i_Data;
  assign last = (cnt_q == CW'(DATA_W - 1));

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      axis_bcd_digit_adj u_adj (.digit(bcd_q[g]), .adj(bcd_adj[g]));
    end
  endgenerate

  // top bit is the carry out of the MSB digit; always 0 when 10^DIGITS > 2^DATA_W
  assign bcd_shl = {bcd_adj, shift_q[DATA_W-1]};
  assign o_Busy  = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Start) state_nxt = SHIFT;
      SHIFT:   if (last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      o_Done  <= 1'b0;
      o_Sign  <= 1'b0;
      o_BCD   <= '0;
    end else begin
      o_Done <= 1'b0;
      if (state == IDLE && i_Start) begin
        shift_q <= mag;
        sign_q  <= neg;
        bcd_q   <= '0;
        cnt_q   <= '0;
      end else if (state == SHIFT) begin
        bcd_q   <= bcd_shl[4*DIGITS-1:0];
        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
        cnt_q   <= cnt_q + CW'(1);
        // outputs only move on the final shift so they never show partial values
        if (last) begin
          o_BCD  <= bcd_shl[4*DIGITS-1:0];
          o_Sign <= sign_q;
          o_Done <= 1'b1;
        end
      end
    end
  end
endmodule
